// File: rtl/des_block_scheduler.sv
// Job scheduler for an array of des_block instances: dispatches seed/limit jobs
// to free blocks, collects finished counters round-robin and recycles blocks.
module des_block_scheduler #(
  parameter int unsigned NUM_BLOCKS = 4,
  parameter int unsigned JOBS_W     = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       go,
  input  logic                       job_valid,
  output logic                       job_ready,
  input  logic [63:0]                job_seed,
  input  logic [63:0]                job_limit,
  input  logic                       job_last,
  output logic [NUM_BLOCKS-1:0]      blk_start,
  output logic [NUM_BLOCKS-1:0]      blk_restart,
  output logic [64*NUM_BLOCKS-1:0]   blk_seed,
  output logic [64*NUM_BLOCKS-1:0]   blk_limit,
  input  logic [NUM_BLOCKS-1:0]      blk_done,
  input  logic [64*NUM_BLOCKS-1:0]   blk_counter,
  output logic [63:0]                total,
  output logic [JOBS_W-1:0]          jobs_done,
  output logic                       busy,
  output logic                       done
);

  localparam int unsigned PTR_W = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} top_e;
  typedef enum logic [1:0] {SL_FREE, SL_LOADED, SL_RUN, SL_COLLECT} slot_e;

  top_e              state_q;
  top_e              state_d;
  slot_e             slot_q [NUM_BLOCKS];
  slot_e             slot_d [NUM_BLOCKS];
  logic              init_q;
  logic [PTR_W-1:0]  rr_ptr_q;
  logic [PTR_W-1:0]  rr_ptr_d;
  logic              free_any;
  logic              all_free;
  logic [PTR_W-1:0]  free_idx;
  logic [NUM_BLOCKS-1:0] req;
  logic              req_any;
  logic [PTR_W-1:0]  grant_idx;
  logic              accept;
  logic              start_batch;

  // Descending scan so the lowest-index free slot is the one left selected.
  always_comb begin
    free_any = 1'b0;
    all_free = 1'b1;
    free_idx = '0;
    for (int unsigned i = NUM_BLOCKS; i > 0; i--) begin
      if (slot_q[i-1] == SL_FREE) begin
        free_any = 1'b1;
        free_idx = PTR_W'(i - 1);
      end else begin
        all_free = 1'b0;
      end
    end
  end

  always_comb begin
    req = '0;
    for (int unsigned i = 0; i < NUM_BLOCKS; i++) begin
      req[i] = (slot_q[i] == SL_RUN) && blk_done[i];
    end
  end

  // Round-robin: scan offsets high to low so the nearest requester from the pointer wins.
  always_comb begin
    req_any   = 1'b0;
    grant_idx = '0;
    for (int unsigned off = NUM_BLOCKS; off > 0; off--) begin
      if (req[(32'(rr_ptr_q) + off - 1) % NUM_BLOCKS]) begin
        req_any   = 1'b1;
        grant_idx = PTR_W'((32'(rr_ptr_q) + off - 1) % NUM_BLOCKS);
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (req_any) begin
      rr_ptr_d = PTR_W'((32'(grant_idx) + 1) % NUM_BLOCKS);
    end
  end

  assign accept      = job_valid && job_ready;
  assign start_batch = go && ((state_q == ST_IDLE) || (state_q == ST_DONE));

  // Top FSM: state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Top FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (go) state_d = ST_RUN;
      ST_RUN:   if (accept && job_last) state_d = ST_DRAIN;
      ST_DRAIN: if (all_free && !init_q) state_d = ST_DONE;
      ST_DONE:  if (go) state_d = ST_RUN;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Top FSM: outputs
  always_comb begin
    job_ready = (state_q == ST_RUN) && free_any;
    busy      = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    done      = (state_q == ST_DONE);
  end

  // Per-slot lifecycle; dispatch and grant never target the same slot.
  always_comb begin
    for (int unsigned i = 0; i < NUM_BLOCKS; i++) begin
      unique case (slot_q[i])
        SL_LOADED:  slot_d[i] = SL_RUN;
        SL_COLLECT: slot_d[i] = SL_FREE;
        default:    slot_d[i] = slot_q[i];
      endcase
    end
    if (accept) begin
      slot_d[free_idx] = SL_LOADED;
    end
    if (req_any) begin
      slot_d[grant_idx] = SL_COLLECT;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_BLOCKS; i++) begin
        slot_q[i] <= SL_FREE;
      end
      init_q    <= 1'b1;
      rr_ptr_q  <= '0;
      total     <= '0;
      jobs_done <= '0;
      blk_seed  <= '0;
      blk_limit <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_BLOCKS; i++) begin
        slot_q[i] <= slot_d[i];
      end
      init_q   <= 1'b0;
      rr_ptr_q <= rr_ptr_d;
      if (start_batch) begin
        total     <= '0;
        jobs_done <= '0;
      end else if (req_any) begin
        total     <= total + blk_counter[{grant_idx, 6'd0} +: 64];
        jobs_done <= jobs_done + JOBS_W'(1);
      end
      if (accept) begin
        blk_seed[{free_idx, 6'd0} +: 64]  <= job_seed;
        blk_limit[{free_idx, 6'd0} +: 64] <= job_limit;
      end
    end
  end

  // init_q holds every block in restart for the cycle following reset.
  always_comb begin
    for (int unsigned i = 0; i < NUM_BLOCKS; i++) begin
      blk_start[i]   = (slot_q[i] == SL_LOADED);
      blk_restart[i] = init_q || (slot_q[i] == SL_COLLECT);
    end
  end

endmodule

// File: doc/des_block_scheduler.md
Name: des_block_scheduler

Overview:
- Distributes a stream of linear-cryptanalysis jobs, each a seed plus counter limit, across NUM_BLOCKS parallel des_block instances.
- Collects each finished block's 64-bit counter into one running total, then recycles the block via its restart_block input.
- Sits between the host/register interface and the des_block array; polynomial, masks and round keys are shared and wired directly, not handled here.

Parameters:
NUM_BLOCKS, 4, number of des_block instances managed (1..16)
JOBS_W, 32, width of completed-job counter

Ports:
clk  input  1  clock
rst  input  1  synchronous reset, active high
go  input  1  pulse: start a new batch (accepted only in IDLE or DONE)
job_valid  input  1  job descriptor valid
job_ready  output  1  scheduler can accept job this cycle
job_seed  input  64  LFSR seed for the job
job_limit  input  64  message count limit for the job
job_last  input  1  marks final job of batch (qualified by valid&ready)
blk_start  output  NUM_BLOCKS  per-block one-cycle start pulse
blk_restart  output  NUM_BLOCKS  per-block one-cycle restart pulse
blk_seed  output  64*NUM_BLOCKS  per-block seed, slot i at [64i+63:64i]
blk_limit  output  64*NUM_BLOCKS  per-block counter limit, same packing
blk_done  input  NUM_BLOCKS  per-block done level
blk_counter  input  64*NUM_BLOCKS  per-block counter, same packing
total  output  64  accumulated sum of collected counters, wraps mod 2^64
jobs_done  output  JOBS_W  number of jobs collected this batch
busy  output  1  high in RUN or DRAIN
done  output  1  high in DONE

Behaviour:
- Reset: top FSM=IDLE, all slots FREE, total=0, jobs_done=0, job_ready=0, blk_start=0, blk_seed=0, blk_limit=0, blk_restart=all ones. The all-ones restart forces every block to init on the first edge after reset; it falls to 0 one cycle after rst deasserts. Reset mid-batch discards all in-flight work.
- Top FSM:
  - IDLE -go-> RUN: clears total and jobs_done.
  - RUN -job_last accepted-> DRAIN.
  - DRAIN -all slots FREE and no restart pending-> DONE.
  - DONE -go-> RUN: clears total and jobs_done.
  - go ignored in RUN and DRAIN.
- job_ready = (state==RUN) and at least one slot FREE. Purely combinational from registered state, no dependency on job_valid.
- Dispatch: on job_valid&job_ready, the lowest-index FREE slot k takes the job.
  - Edge t: blk_seed[k] and blk_limit[k] registered, slot -> LOADED.
  - Cycle t+1: blk_start[k]=1 for exactly one cycle, slot -> RUN at the end of t+1.
  - At most one dispatch per cycle.
  - blk_seed/blk_limit hold stable until the next dispatch to that slot.
- Collection: slots in RUN with blk_done=1 request; a round-robin arbiter grants one per cycle.
  - Pointer starts at 0 after reset and advances to granted index+1.
  - On the grant edge: total += blk_counter[g] (64-bit wrap) and jobs_done += 1 (wraps).
  - Next cycle: blk_restart[g]=1 for one cycle, slot -> FREE after that cycle.
- Slot states: FREE, LOADED, RUN, COLLECT (the restart cycle).
  - A slot is never dispatchable in its restart cycle.
  - blk_done is ignored unless the slot is in RUN. A stale done in LOADED or COLLECT is never counted.
- Simultaneous events: dispatch and collection in the same cycle are independent and both happen. go coinciding with job_valid in IDLE: go is processed, and the job is not accepted that cycle (job_ready=0 in IDLE).
- job_limit=0 is passed through unmodified; blocks completing immediately are collected normally.

Test Plan:
- NUM_BLOCKS=4, go, one job (seed=0x1, limit=100, last=1), model blk_done after 120 cycles with counter=37 -> blk_start[0] pulses at accept+1; blk_restart[0] pulses one cycle after grant; total=37, jobs_done=1, done=1.
- Four jobs back-to-back, counters 10,20,30,40 -> slots 0..3 used in order, job_ready drops after 4th accept, total=100, jobs_done=4.
- Five jobs, 5th held by job_ready=0 until slot 2 finishes first -> 5th job lands in slot 2 exactly two cycles after slot 2's grant; final jobs_done=5.
- All four blk_done rise in the same cycle -> grants on consecutive cycles in order 0,1,2,3; next simultaneous batch starts at the pointer's current position; sum correct.
- rst asserted while three slots RUN -> outputs at reset values, blk_restart all ones during reset then 0, total=0, no counter from old blocks added after reset.
- Batch finishes (total=0xFFFFFFFFFFFFFFFF-5), then go in DONE with a job returning counter 10 -> total cleared first; result total=10. A separate run checks wrap: accumulating 0xFFFFFFFFFFFFFFFF + 2 gives 1.
